// File: rtl/qs_pkg.sv
// Shared types for the qs egress path: datum, FIFO entry, status flags, framing state.
package qs_pkg;

  localparam int unsigned W_BITS = 32;

  typedef logic [W_BITS-1:0] w_t;

  typedef struct packed {
    logic sop;
    logic eop;
    w_t   dat;
  } egr_t;

  typedef struct packed {
    logic sorted;
    logic frm_err;
    logic qs_err;
  } sts_flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } frm_state_t;

endpackage

// File: rtl/qs_egress_fifo.sv
// Synchronous FIFO whose head is held in registers, so a write into an empty FIFO
// is visible on the head one cycle later and one pop per cycle is sustained.
module qs_egress_fifo #(
  parameter int unsigned DW    = 34,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic          full_c,
  output logic          head_vld_r,
  output logic [DW-1:0] head_r
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic          empty_c, rd_go_c, wr_go_c;
  logic [DW-1:0] head_nx_c;

  // A pop frees its slot in the same cycle, so a full FIFO still accepts a write then.
  always_comb begin
    full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    empty_c   = (wr_ptr == rd_ptr);
    rd_go_c   = rd_en & ~empty_c;
    wr_go_c   = wr_en & (~full_c | rd_go_c);
    rd_ptr_nx = rd_ptr + {{AW{1'b0}}, rd_go_c};
    wr_ptr_nx = wr_ptr + {{AW{1'b0}}, wr_go_c};
    head_nx_c = (rd_ptr_nx == wr_ptr) ? wr_data : mem[rd_ptr_nx[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (wr_go_c) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      head_vld_r <= 1'b0;
      head_r     <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nx;
      rd_ptr     <= rd_ptr_nx;
      head_vld_r <= (wr_ptr_nx != rd_ptr_nx);
      head_r     <= head_nx_c;
    end
  end

endmodule

// File: rtl/qs_egress.sv
// Egress stage for the qs sorter: buffers sorted beats, checks packet framing and
// ordering, and reports one status strobe per closed packet.
module qs_egress
  import qs_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic             in_err,
  input  logic [W-1:0]     in_dat,
  output logic             out_vld_r,
  output logic             out_sop_r,
  output logic             out_eop_r,
  output logic [W-1:0]     out_dat_r,
  input  logic             out_rdy,
  output logic             sts_vld_r,
  output logic             sts_sorted_r,
  output logic             sts_frm_err_r,
  output logic             sts_qs_err_r,
  output logic [LEN_W-1:0] sts_len_r,
  output logic             ovf_r
);

  localparam int unsigned EW = $bits(egr_t);

  egr_t             wr_ent, head;
  logic             head_vld, full_c, pop_c;
  frm_state_t       state;
  sts_flags_t       acc, nxt_c, old_c, pend, sts_r;
  logic [LEN_W-1:0] acc_len, nxt_len_c, pend_len;
  logic [W-1:0]     prev;
  logic             pend_vld, start_c, close_c, eop_c, drop_c;

  assign wr_ent = '{sop: in_sop, eop: in_eop, dat: w_t'(in_dat)};
  assign pop_c  = out_vld_r & out_rdy;

  qs_egress_fifo #(.DW(EW), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (in_vld),
    .wr_data    (wr_ent),
    .rd_en      (pop_c),
    .full_c     (full_c),
    .head_vld_r (head_vld),
    .head_r     (head)
  );

  assign out_vld_r     = head_vld;
  assign out_sop_r     = head.sop;
  assign out_eop_r     = head.eop;
  assign out_dat_r     = W'(head.dat);
  assign sts_sorted_r  = sts_r.sorted;
  assign sts_frm_err_r = sts_r.frm_err;
  assign sts_qs_err_r  = sts_r.qs_err;

  // Accumulators after this beat; a beat opening a packet restarts them from itself.
  always_comb begin
    start_c = in_sop | (state == ST_IDLE);
    close_c = in_vld & in_sop & (state == ST_PKT);
    eop_c   = in_vld & in_eop;
    drop_c  = in_vld & full_c & ~pop_c;
    old_c   = acc;
    old_c.frm_err = 1'b1;
    if (start_c) begin
      nxt_c.sorted  = 1'b1;
      nxt_c.frm_err = ((state == ST_IDLE) & ~in_sop) | drop_c;
      nxt_c.qs_err  = in_err;
      nxt_len_c     = LEN_W'(1);
    end else begin
      nxt_c.sorted  = acc.sorted & ~(in_dat < prev);
      nxt_c.frm_err = acc.frm_err | drop_c;
      nxt_c.qs_err  = acc.qs_err | in_err;
      nxt_len_c     = (&acc_len) ? acc_len : acc_len + LEN_W'(1);
    end
  end

  // A forced close plus eop on one beat yields two statuses; the second waits in pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      acc_len   <= '0;
      prev      <= '0;
      pend_vld  <= 1'b0;
      pend      <= '0;
      pend_len  <= '0;
      sts_vld_r <= 1'b0;
      sts_r     <= '0;
      sts_len_r <= '0;
      ovf_r     <= 1'b0;
    end else begin
      sts_vld_r <= 1'b0;
      pend_vld  <= 1'b0;
      if (drop_c) ovf_r <= 1'b1;
      if (in_vld) begin
        state   <= in_eop ? ST_IDLE : ST_PKT;
        acc     <= nxt_c;
        acc_len <= nxt_len_c;
        prev    <= in_dat;
      end
      if (pend_vld) begin
        sts_vld_r <= 1'b1;
        sts_r     <= pend;
        sts_len_r <= pend_len;
        pend_vld  <= eop_c;
        pend      <= nxt_c;
        pend_len  <= nxt_len_c;
      end else if (close_c) begin
        sts_vld_r <= 1'b1;
        sts_r     <= old_c;
        sts_len_r <= acc_len;
        pend_vld  <= eop_c;
        pend      <= nxt_c;
        pend_len  <= nxt_len_c;
      end else if (eop_c) begin
        sts_vld_r <= 1'b1;
        sts_r     <= nxt_c;
        sts_len_r <= nxt_len_c;
      end
    end
  end

endmodule
